// File: rtl/nibble_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_sel_pkg
//  Description : Shared definitions for the nibble select pipeline. Holds the
//                per-lane mode encodings and the nibble extraction helpers
//                used by the lane-select logic.
//  Revision    : 1.0  initial release
// ============================================================================
package nibble_sel_pkg;

    // Per-lane mode encodings
    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_ZERO = 2'b11;

    // A package function cannot see module parameters, so the helpers work
    // on fixed maximum widths. Callers zero-extend operands and truncate
    // results to their own DATA_W / NIB_W.
    localparam int unsigned PICK_MAX_DATA_W = 256;
    localparam int unsigned PICK_MAX_NIB_W  = 64;

    // Returns nibble 'idx' of 'data', with nibbles nib_w bits wide.
    // Only the low nib_w bits of the result are meaningful.
    function automatic logic [PICK_MAX_NIB_W-1:0] nib_pick(
        input logic [PICK_MAX_DATA_W-1:0] data,
        input int unsigned                idx,
        input int unsigned                nib_w
    );
        logic [PICK_MAX_DATA_W-1:0] shifted;
        shifted = data >> (idx * nib_w);
        return shifted[PICK_MAX_NIB_W-1:0];
    endfunction

    // Combines the two picked nibbles according to the lane mode.
    function automatic logic [PICK_MAX_NIB_W-1:0] lane_op(
        input logic [1:0]                mode,
        input logic [PICK_MAX_NIB_W-1:0] a,
        input logic [PICK_MAX_NIB_W-1:0] b
    );
        logic [PICK_MAX_NIB_W-1:0] res;
        case (mode)
            MODE_A:   res = a;
            MODE_B:   res = b;
            MODE_XOR: res = a ^ b;
            default:  res = '0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_fifo
//  Description : DEPTH-entry synchronous FIFO with valid/ready on both sides.
//                Write side is ready whenever the FIFO is not full,
//                independent of the read side. Head data is forced to zero
//                while empty so the output is never undefined even though the
//                storage itself is not reset.
//  Revision    : 1.0  initial release
//
//  Ports:
//    clk       in   clock, rising edge
//    rst       in   synchronous active-high reset
//    wr_valid  in   write request
//    wr_ready  out  FIFO not full
//    wr_data   in   WIDTH  write data
//    rd_valid  out  FIFO not empty
//    rd_ready  in   consumer takes head
//    rd_data   out  WIDTH  head entry, zero when empty
//    level     out  PTR_W+1  occupancy
// ============================================================================
module nibble_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign wr_ready = (level != FULL_LEVEL);
    assign rd_valid = (level != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;

    // Storage carries no reset; the empty gating on rd_data hides its contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PTR_W + 1)'(1);
                2'b01:   level <= level - (PTR_W + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/nibble_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_select_pipe
//  Description : Per-lane nibble selector feeding an output FIFO. Each lane
//                picks a nibble from DATA_A, DATA_B, their XOR, or zero; the
//                packed lane results are captured into the FIFO on every
//                accepted request. XFER_CNT counts accepted requests.
//  Revision    : 1.0  initial release
//
//  Ports:
//    CLK         in   clock, rising edge
//    RESET       in   synchronous active-high reset
//    IN_VALID    in   request valid
//    IN_READY    out  request can be accepted (FIFO not full)
//    DATA_A      in   DATA_W  source A
//    DATA_B      in   DATA_W  source B
//    SEL_A       in   LANES*IDX_W  lane i index into A at [i*IDX_W +: IDX_W]
//    SEL_B       in   LANES*IDX_W  lane i index into B
//    MODE        in   LANES*2  lane i mode at [i*2 +: 2]
//    OUT_VALID   out  FIFO head valid
//    OUT_READY   in   consumer accepts head
//    NIBBLE_OUT  out  LANES*NIB_W  head entry, zero when empty
//    LEVEL       out  PTR_W+1  FIFO occupancy
//    XFER_CNT    out  CNT_W  accepted-request counter, wraps
// ============================================================================
module nibble_select_pipe
    import nibble_sel_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NIB_W  = 4,
    parameter  int LANES  = 4,
    parameter  int DEPTH  = 2,
    parameter  int CNT_W  = 16,
    localparam int NNIB   = DATA_W / NIB_W,
    localparam int IDX_W  = $clog2(NNIB),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [DATA_W-1:0]      DATA_A,
    input  logic [DATA_W-1:0]      DATA_B,
    input  logic [LANES*IDX_W-1:0] SEL_A,
    input  logic [LANES*IDX_W-1:0] SEL_B,
    input  logic [LANES*2-1:0]     MODE,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES*NIB_W-1:0] NIBBLE_OUT,
    output logic [PTR_W:0]         LEVEL,
    output logic [CNT_W-1:0]       XFER_CNT
);

    logic [LANES*NIB_W-1:0] lane_word;
    logic                   push;

    // Lane select: purely combinational, only captured on push.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IDX_W-1:0] idx_a;
        logic [IDX_W-1:0] idx_b;
        logic [NIB_W-1:0] nib_a;
        logic [NIB_W-1:0] nib_b;

        assign idx_a = SEL_A[i*IDX_W +: IDX_W];
        assign idx_b = SEL_B[i*IDX_W +: IDX_W];

        assign nib_a = NIB_W'(nib_pick(PICK_MAX_DATA_W'(DATA_A), 32'(idx_a), NIB_W));
        assign nib_b = NIB_W'(nib_pick(PICK_MAX_DATA_W'(DATA_B), 32'(idx_b), NIB_W));

        assign lane_word[i*NIB_W +: NIB_W] =
            NIB_W'(lane_op(MODE[i*2 +: 2],
                           PICK_MAX_NIB_W'(nib_a),
                           PICK_MAX_NIB_W'(nib_b)));
    end

    nibble_fifo #(
        .WIDTH (LANES * NIB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RESET),
        .wr_valid (IN_VALID),
        .wr_ready (IN_READY),
        .wr_data  (lane_word),
        .rd_valid (OUT_VALID),
        .rd_ready (OUT_READY),
        .rd_data  (NIBBLE_OUT),
        .level    (LEVEL)
    );

    assign push = IN_VALID & IN_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            XFER_CNT <= '0;
        end else if (push) begin
            XFER_CNT <= XFER_CNT + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_select_pipe
//  Description : Self-checking bench for nibble_select_pipe. A queue-based
//                reference model tracks expected FIFO contents and counter.
//                A second instance checks a wide parameter set.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nibble_select_pipe;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [11:0] sel_a;
    logic [11:0] sel_b;
    logic [7:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] nib_out;
    logic [1:0]  level;
    logic [15:0] xfer_cnt;

    // Wide instance: DATA_W=64, NIB_W=8, LANES=8, DEPTH=4
    logic        wd_in_valid;
    logic        wd_in_ready;
    logic [63:0] wd_data_a;
    logic [63:0] wd_data_b;
    logic [23:0] wd_sel_a;
    logic [23:0] wd_sel_b;
    logic [15:0] wd_mode;
    logic        wd_out_valid;
    logic [63:0] wd_nib_out;
    logic [2:0]  wd_level;
    logic [15:0] wd_xfer_cnt;

    nibble_select_pipe dut (
        .CLK        (clk),
        .RESET      (reset),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .DATA_A     (data_a),
        .DATA_B     (data_b),
        .SEL_A      (sel_a),
        .SEL_B      (sel_b),
        .MODE       (mode),
        .OUT_VALID  (out_valid),
        .OUT_READY  (out_ready),
        .NIBBLE_OUT (nib_out),
        .LEVEL      (level),
        .XFER_CNT   (xfer_cnt)
    );

    nibble_select_pipe #(
        .DATA_W (64),
        .NIB_W  (8),
        .LANES  (8),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut_wide (
        .CLK        (clk),
        .RESET      (reset),
        .IN_VALID   (wd_in_valid),
        .IN_READY   (wd_in_ready),
        .DATA_A     (wd_data_a),
        .DATA_B     (wd_data_b),
        .SEL_A      (wd_sel_a),
        .SEL_B      (wd_sel_b),
        .MODE       (wd_mode),
        .OUT_VALID  (wd_out_valid),
        .OUT_READY  (1'b0),
        .NIBBLE_OUT (wd_nib_out),
        .LEVEL      (wd_level),
        .XFER_CNT   (wd_xfer_cnt)
    );

    int          total = 0;
    int          bad   = 0;
    logic [15:0] mq[$];
    logic [15:0] mcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference lane function: nibble j of X is (X / 16^j) mod 16.
    function automatic logic [15:0] ref_lanes(input logic [31:0] a, input logic [31:0] b,
                                              input logic [11:0] sa, input logic [11:0] sb,
                                              input logic [7:0] m);
        logic [15:0] r;
        int          ia, ib, na, nb, md, res;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            ia = int'((sa >> (3 * i)) % 12'd8);
            ib = int'((sb >> (3 * i)) % 12'd8);
            md = int'((m >> (2 * i)) % 8'd4);
            na = int'((a >> (4 * ia)) % 32'd16);
            nb = int'((b >> (4 * ib)) % 32'd16);
            case (md)
                0:       res = na;
                1:       res = nb;
                2:       res = na ^ nb;
                default: res = 0;
            endcase
            r = r | (16'(res) << (4 * i));
        end
        return r;
    endfunction

    task automatic check_all();
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready",  64'(in_ready),  64'(mq.size() != DEPTH));
        chk("level",     64'(level),     64'(mq.size()));
        chk("nibble_out", 64'(nib_out),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
        chk("xfer_cnt",  64'(xfer_cnt),  64'(mcnt));
    endtask

    // One clock: apply handshake inputs, advance the model, optionally check.
    task automatic cycle(input bit iv, input bit ordy, input bit do_chk);
        bit          do_push;
        bit          do_pop;
        logic [15:0] v;
        in_valid  = iv;
        out_ready = ordy;
        v       = ref_lanes(data_a, data_b, sel_a, sel_b, mode);
        do_push = iv && (mq.size() < DEPTH);
        do_pop  = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            mcnt = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(v);
                mcnt = mcnt + 16'd1;
            end
        end
        if (do_chk) check_all();
    endtask

    task automatic rand_inputs();
        data_a = $urandom;
        data_b = $urandom;
        sel_a  = 12'($urandom);
        sel_b  = 12'($urandom);
        mode   = 8'($urandom);
    endtask

    initial begin
        logic [15:0] exp_head;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        data_a = '0; data_b = '0; sel_a = '0; sel_b = '0; mode = '0;
        wd_in_valid = 1'b0;
        wd_data_a = 64'h0706050403020100;
        wd_data_b = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) wd_sel_a[i*3 +: 3] = 3'(7 - i);
        wd_sel_b = 24'($urandom);
        wd_mode  = '0;
        mcnt = '0;

        // Reset state
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_nibble",    64'(nib_out),   64'd0);
        chk("rst_xfer",      64'(xfer_cnt),  64'd0);
        reset = 1'b0;

        // Wide parameter set: lane i picks byte 7-i in MODE_A
        wd_in_valid = 1'b1;
        cycle(0, 0, 1);
        chk("wide_nibble",    wd_nib_out,       64'h0001020304050607);
        chk("wide_out_valid", 64'(wd_out_valid), 64'd1);
        chk("wide_level1",    64'(wd_level),     64'd1);
        repeat (4) cycle(0, 0, 0);
        wd_in_valid = 1'b0;
        chk("wide_level_full", 64'(wd_level),    64'd4);
        chk("wide_in_ready",   64'(wd_in_ready), 64'd0);
        chk("wide_xfer",       64'(wd_xfer_cnt), 64'd4);

        // Lane modes
        data_a = 32'h76543210;
        data_b = 32'hFEDCBA98;
        sel_a  = {3'd7, 3'd7, 3'($urandom), 3'd3};
        sel_b  = {3'($urandom), 3'd7, 3'd0, 3'($urandom)};
        mode   = 8'b11_10_01_00;
        cycle(1, 0, 1);
        chk("lane_modes_nib",   64'(nib_out),   64'h0883);
        chk("lane_modes_valid", 64'(out_valid), 64'd1);
        chk("lane_modes_level", 64'(level),     64'd1);
        chk("lane_modes_cnt",   64'(xfer_cnt),  64'd1);
        cycle(0, 1, 1);

        // Backpressure: third request held until one pop
        rand_inputs(); cycle(1, 0, 1);
        rand_inputs(); cycle(1, 0, 1);
        chk("bp_level2", 64'(level), 64'd2);
        rand_inputs(); cycle(1, 0, 1);
        chk("bp_blocked_ready", 64'(in_ready), 64'd0);
        chk("bp_blocked_level", 64'(level),    64'd2);
        cycle(1, 1, 1);
        cycle(1, 0, 1);
        chk("bp_third_cnt", 64'(xfer_cnt), 64'd4);
        cycle(0, 1, 1);
        cycle(0, 1, 1);
        cycle(0, 1, 1);

        // Simultaneous push/pop at level 1
        rand_inputs(); cycle(1, 0, 1);
        rand_inputs();
        exp_head = ref_lanes(data_a, data_b, sel_a, sel_b, mode);
        cycle(1, 1, 1);
        chk("pp_level", 64'(level),   64'd1);
        chk("pp_head",  64'(nib_out), 64'(exp_head));
        cycle(0, 1, 1);

        // Reset mid-stream with a full FIFO
        rand_inputs(); cycle(1, 0, 1);
        rand_inputs(); cycle(1, 0, 1);
        reset = 1'b1;
        cycle(1, 1, 1);
        reset = 1'b0;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_nibble",    64'(nib_out),   64'd0);
        chk("mrst_level",     64'(level),     64'd0);
        chk("mrst_in_ready",  64'(in_ready),  64'd1);
        chk("mrst_xfer",      64'(xfer_cnt),  64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, 1);
        end

        // Counter wrap after 65536 pushes
        reset = 1'b1;
        cycle(0, 0, 0);
        reset = 1'b0;
        rand_inputs();
        for (int n = 0; n < 65535; n++) cycle(1, 1, 0);
        chk("wrap_pre", 64'(xfer_cnt), 64'hFFFF);
        cycle(1, 1, 1);
        chk("wrap_zero", 64'(xfer_cnt), 64'd0);
        cycle(0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
